// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Sizes, address bases, state encoding and the shift/saturate
//               helper for the dense-layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int IN_N      = 120;
    localparam int HID_N     = 84;
    localparam int OUT_N     = 10;
    localparam int DW        = 16;
    localparam int FRAC      = 8;
    localparam int ACC_W     = 40;

    localparam int L2_W_BASE = IN_N * HID_N;
    localparam int L2_B_BASE = HID_N;

    localparam int IN_AW     = 7;
    localparam int W_AW      = 14;
    localparam int B_AW      = 7;
    localparam int CLS_W     = 4;
    localparam int CNT_W     = 7;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_L1_BIAS = 4'd1,
        S_L1_MAC  = 4'd2,
        S_L1_WB   = 4'd3,
        S_L2_BIAS = 4'd4,
        S_L2_MAC  = 4'd5,
        S_L2_WB   = 4'd6,
        S_ARGMAX  = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Q(ACC) -> Q8.8: drop the extra fractional bits, then clamp to the word range.
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] value);
        logic signed [ACC_W-1:0] shifted;
        shifted = value >>> FRAC;
        if (shifted > ACC_SAT_MAX) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < ACC_SAT_MIN) begin
            return {1'b1, {(DW-1){1'b0}}};
        end
        return shifted[DW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_sequencer_if
// Description : Start/status handshake and memory-port bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_sequencer_if;
    import fc_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [CLS_W-1:0]     classified;
    logic                 rd_en;
    logic [IN_AW-1:0]     in_addr;
    logic [DW-1:0]        in_data;
    logic [W_AW-1:0]      w_addr;
    logic [DW-1:0]        w_data;
    logic [B_AW-1:0]      b_addr;
    logic [DW-1:0]        b_data;

    modport master (
        input  start, in_data, w_data, b_data,
        output busy, done, classified, rd_en, in_addr, w_addr, b_addr
    );

    modport slave (
        output start, in_data, w_data, b_data,
        input  busy, done, classified, rd_en, in_addr, w_addr, b_addr
    );

endinterface
`default_nettype wire

// File: rtl/fc_mac.sv
`default_nettype none
// ============================================================================
// Module      : fc_mac
// Description : Shared multiply-accumulate with bias load, final add,
//               shift/saturate and optional ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_mac
    import fc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_bias,
    input  logic                 accumulate,
    input  logic                 relu,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] bias,
    output logic signed [DW-1:0] result
);

    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_final;
    logic signed [DW-1:0]    w_sat;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod     = (2*DW)'(a) * (2*DW)'(b);
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    // Bias is Q8.8; align it to the Q16.16 product scale before loading.
    assign w_bias_ext = {{(ACC_W-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
    assign w_final    = r_acc + w_prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (load_bias) begin
            r_acc <= w_bias_ext;
        end else if (accumulate) begin
            r_acc <= w_final;
        end
    end

    assign w_sat  = sat_shift(w_final);
    assign result = (relu && w_sat[DW-1]) ? '0 : w_sat;

endmodule
`default_nettype wire

// File: rtl/fc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_sequencer
// Description : Two-layer dense classifier controller (120->84->10) with a
//               shared MAC, hidden/output buffers and a serial argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_sequencer
    import fc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fc_sequencer_if.master bus
);

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_o;
    logic [CNT_W-1:0]       r_k;

    logic signed [DW-1:0]   r_hidden [HID_N];
    logic signed [DW-1:0]   r_out    [OUT_N];
    logic signed [DW-1:0]   r_hid_data;
    logic signed [DW-1:0]   r_best;
    logic [CLS_W-1:0]       r_idx;
    logic [CLS_W-1:0]       r_classified;
    logic                   r_done;

    logic                   w_mac;
    logic                   w_layer2;
    logic                   w_last_k;
    logic                   w_last_o;
    logic                   w_arg_better;
    logic signed [DW-1:0]   w_arg_val;
    logic signed [DW-1:0]   w_mac_a;
    logic signed [DW-1:0]   w_mac_result;

    assign w_mac    = (r_state == S_L1_MAC) || (r_state == S_L2_MAC);
    assign w_layer2 = (r_state == S_L2_MAC) || (r_state == S_L2_WB);

    always_comb begin
        w_last_k = 1'b0;
        w_last_o = 1'b0;
        case (r_state)
            S_L1_MAC: w_last_k = (r_k == CNT_W'(IN_N - 1));
            S_L2_MAC: w_last_k = (r_k == CNT_W'(HID_N - 1));
            S_ARGMAX: w_last_k = (r_k == CNT_W'(OUT_N - 1));
            S_L1_WB:  w_last_o = (r_o == CNT_W'(HID_N - 1));
            S_L2_WB:  w_last_o = (r_o == CNT_W'(OUT_N - 1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_L1_BIAS;
            S_L1_BIAS: w_next = S_L1_MAC;
            S_L1_MAC:  if (w_last_k) w_next = S_L1_WB;
            S_L1_WB:   w_next = w_last_o ? S_L2_BIAS : S_L1_BIAS;
            S_L2_BIAS: w_next = S_L2_MAC;
            S_L2_MAC:  if (w_last_k) w_next = S_L2_WB;
            S_L2_WB:   w_next = w_last_o ? S_ARGMAX : S_L2_BIAS;
            S_ARGMAX:  if (w_last_k) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // r_o walks neurons, r_k walks operands and is reused as the argmax index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_o <= '0;
                    r_k <= '0;
                end
                S_L1_BIAS, S_L2_BIAS: r_k <= '0;
                S_L1_MAC, S_L2_MAC, S_ARGMAX: r_k <= r_k + CNT_W'(1);
                S_L1_WB, S_L2_WB: begin
                    r_k <= '0;
                    r_o <= w_last_o ? '0 : r_o + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_mac_a = w_layer2 ? r_hid_data : signed'(bus.in_data);

    fc_mac u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_bias  (w_mac && (r_k == '0)),
        .accumulate (w_mac && (r_k != '0)),
        .relu       (r_state == S_L1_WB),
        .a          (w_mac_a),
        .b          (signed'(bus.w_data)),
        .bias       (signed'(bus.b_data)),
        .result     (w_mac_result)
    );

    // Hidden reads are registered so layer 2 sees the same one-cycle operand latency as the RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_L1_WB) begin
            r_hidden[r_o] <= w_mac_result;
        end
        if (r_state == S_L2_WB) begin
            r_out[r_o[CLS_W-1:0]] <= w_mac_result;
        end
        if (r_state == S_L2_MAC) begin
            r_hid_data <= r_hidden[r_k];
        end
    end

    assign w_arg_val    = r_out[r_k[CLS_W-1:0]];
    assign w_arg_better = (w_arg_val > r_best);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best       <= '0;
            r_idx        <= '0;
            r_classified <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_ARGMAX) begin
                if (r_k == '0) begin
                    r_best <= w_arg_val;
                    r_idx  <= '0;
                end else if (w_arg_better) begin
                    r_best <= w_arg_val;
                    r_idx  <= r_k[CLS_W-1:0];
                end
                // Fold the last comparison in so classified and done move on the same edge.
                if (w_last_k) begin
                    r_done       <= 1'b1;
                    r_classified <= w_arg_better ? r_k[CLS_W-1:0] : r_idx;
                end
            end
        end
    end

    always_comb begin
        bus.rd_en   = 1'b0;
        bus.in_addr = '0;
        bus.w_addr  = '0;
        bus.b_addr  = '0;
        case (r_state)
            S_L1_BIAS: begin
                bus.rd_en  = 1'b1;
                bus.b_addr = r_o;
            end
            S_L2_BIAS: begin
                bus.rd_en  = 1'b1;
                bus.b_addr = B_AW'(L2_B_BASE) + r_o;
            end
            S_L1_MAC: begin
                bus.rd_en   = 1'b1;
                bus.in_addr = r_k;
                bus.w_addr  = W_AW'(r_o) * W_AW'(IN_N) + W_AW'(r_k);
            end
            S_L2_MAC: begin
                bus.rd_en  = 1'b1;
                bus.w_addr = W_AW'(L2_W_BASE) + W_AW'(r_o) * W_AW'(HID_N) + W_AW'(r_k);
            end
            default: ;
        endcase
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.classified = r_classified;

endmodule
`default_nettype wire

// File: tb/tb_fc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_sequencer
// Description : Scoreboard bench: behavioural reference classifier, ROM/RAM
//               models, timing and address checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_sequencer;
    import fc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_sequencer_if bus ();

    fc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] feat  [128];
    logic [15:0] w_rom [16384];
    logic [15:0] b_rom [128];

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [3:0]  sb [$];
    logic [3:0]  prev_class = 4'd0;

    always @(posedge clk) begin
        bus.in_data <= feat[bus.in_addr];
        bus.w_data  <= w_rom[bus.w_addr];
        bus.b_data  <= b_rom[bus.b_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] m_sat(input longint v);
        longint s;
        s = v >>> 8;
        if (s > 32767)  return 16'sh7fff;
        if (s < -32768) return 16'sh8000;
        return 16'(s);
    endfunction

    function automatic logic [3:0] model_class();
        logic signed [15:0] hid [84];
        logic signed [15:0] ov  [10];
        logic signed [15:0] bv;
        logic [3:0]         bi;
        longint             acc;
        for (int o = 0; o < 84; o++) begin
            acc = longint'($signed(b_rom[o])) * 256;
            for (int k = 0; k < 120; k++)
                acc += longint'($signed(feat[k])) * longint'($signed(w_rom[o*120 + k]));
            hid[o] = m_sat(acc);
            if (hid[o] < 0) hid[o] = 16'sh0000;
        end
        for (int o = 0; o < 10; o++) begin
            acc = longint'($signed(b_rom[84 + o])) * 256;
            for (int k = 0; k < 84; k++)
                acc += longint'(hid[k]) * longint'($signed(w_rom[10080 + o*84 + k]));
            ov[o] = m_sat(acc);
        end
        bi = 4'd0;
        bv = ov[0];
        for (int i = 1; i < 10; i++) begin
            if (ov[i] > bv) begin
                bv = ov[i];
                bi = 4'(i);
            end
        end
        return bi;
    endfunction

    task automatic fill(input logic [15:0] fv, input logic [15:0] w1, input logic [15:0] w2,
                        input logic [15:0] b1, input logic [15:0] b2);
        for (int i = 0; i < 128; i++)   feat[i]  = fv;
        for (int i = 0; i < 16384; i++) w_rom[i] = (i < 10080) ? w1 : w2;
        for (int i = 0; i < 128; i++)   b_rom[i] = (i < 84) ? b1 : b2;
    endtask

    task automatic run_case(input bit addr_chk, input bit pulses, input int abort_at);
        bit seen;
        seen = 1'b0;
        sb.push_back(model_class());
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 11120; cyc++) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_rd_en", 32'(bus.rd_en), 32'd0);
                check("abort_class", 32'(bus.classified), 32'd0);
                repeat (3) @(posedge clk);
                #1 check("abort_done", 32'(bus.done), 32'd0);
                if (sb.size() > 0) void'(sb.pop_front());
                prev_class = 4'd0;
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            if (cyc == 1) check("busy_start", 32'(bus.busy), 32'd1);
            if (addr_chk) begin
                if (cyc == 1) begin
                    check("rd_en_c1", 32'(bus.rd_en), 32'd1);
                    check("b_addr_c1", 32'(bus.b_addr), 32'd0);
                end
                if (cyc >= 2 && cyc <= 121) begin
                    check("w_addr_l1", 32'(bus.w_addr), 32'(cyc - 2));
                    check("in_addr_l1", 32'(bus.in_addr), 32'(cyc - 2));
                end
                if (cyc == 122)   check("rd_en_wb", 32'(bus.rd_en), 32'd0);
                if (cyc == 123)   check("b_addr_c123", 32'(bus.b_addr), 32'd1);
                if (cyc == 10249) check("b_addr_l2", 32'(bus.b_addr), 32'd84);
                if (cyc == 10250) check("w_addr_l2", 32'(bus.w_addr), 32'd10080);
            end
            if (cyc == 11118) check("class_hold", 32'(bus.classified), 32'(prev_class));
            if (bus.done) begin
                check("done_cycle", 32'(cyc), 32'd11119);
                if (!seen && sb.size() > 0) begin
                    prev_class = sb.pop_front();
                    check("classified", 32'(bus.classified), 32'(prev_class));
                end
                seen = 1'b1;
            end
            if (cyc == 11120) begin
                check("busy_end", 32'(bus.busy), 32'd0);
                check("done_end", 32'(bus.done), 32'd0);
            end
            if (pulses) begin
                if (cyc == 50 || cyc == 10249 || cyc == 11118) bus.start = 1'b1;
                if (cyc == 51 || cyc == 10250 || cyc == 11119) bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        if (!seen) begin
            check("done_seen", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        bus.start = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_class", 32'(bus.classified), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_addr", 32'({bus.in_addr, bus.w_addr, bus.b_addr}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        fill(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        b_rom[84 + 7] = 16'h0100;
        run_case(1'b1, 1'b0, 0);

        fill(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
        run_case(1'b0, 1'b1, 0);

        fill(16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'hFE00);
        b_rom[84 + 3] = 16'hFF80;
        for (int k = 0; k < 84; k++) w_rom[10080 + k] = 16'hFF00;
        run_case(1'b0, 1'b0, 0);

        fill(16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 84; k++) w_rom[10080 + 5*84 + k] = 16'h0100;
        run_case(1'b0, 1'b0, 0);

        fill(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        b_rom[84 + 7] = 16'h0100;
        run_case(1'b0, 1'b0, 5000);
        run_case(1'b0, 1'b0, 0);

        for (int i = 0; i < 128; i++)   feat[i]  = 16'($urandom_range(0, 511)) - 16'd256;
        for (int i = 0; i < 16384; i++) w_rom[i] = 16'($urandom_range(0, 255)) - 16'd128;
        for (int i = 0; i < 128; i++)   b_rom[i] = 16'($urandom_range(0, 511)) - 16'd256;
        b_rom[84 + 2] = 16'h0300;
        b_rom[84 + 9] = 16'h8000;
        run_case(1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
